// File: rtl/apb_fsm_controller.sv
// Sequencing core of the AHB2APB bridge: takes one AHB transfer at a time and
// runs it through the APB SETUP/ACCESS phases, stalling AHB while busy.
module apb_fsm_controller #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ACCESS_WAIT = 0
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [2:0]        Tempselx,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [2:0]        Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_WSETUP,
        ST_WACCESS,
        ST_RSETUP,
        ST_RACCESS
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(ACCESS_WAIT);

    state_t            state_q,     state_d;
    logic [3:0]        wait_cnt_q,  wait_cnt_d;
    logic [2:0]        sel_q,       sel_d;
    logic [2:0]        pselx_q,     pselx_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              hreadyout_q, hreadyout_d;
    logic              accept;

    // Hreadyout_q is high exactly in IDLE and on the last ACCESS cycle,
    // so it doubles as the "may accept now" qualifier.
    assign accept = Valid && hreadyout_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        sel_d      = sel_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d    = Tempselx;
                    paddr_d  = Haddr;
                    pwrite_d = Hwrite;
                    state_d  = Hwrite ? ST_WWAIT : ST_RSETUP;
                end
            end
            ST_WWAIT: begin
                pwdata_d = Hwdata;
                state_d  = ST_WSETUP;
            end
            ST_WSETUP: begin
                wait_cnt_d = 4'd0;
                state_d    = ST_WACCESS;
            end
            ST_RSETUP: begin
                wait_cnt_d = 4'd0;
                state_d    = ST_RACCESS;
            end
            ST_WACCESS, ST_RACCESS: begin
                if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end else if (accept) begin
                    sel_d    = Tempselx;
                    paddr_d  = Haddr;
                    pwrite_d = Hwrite;
                    state_d  = Hwrite ? ST_WWAIT : ST_RSETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        pselx_d     = (state_d inside {ST_WSETUP, ST_WACCESS, ST_RSETUP, ST_RACCESS})
                      ? sel_d : 3'b000;
        penable_d   = (state_d inside {ST_WACCESS, ST_RACCESS});
        hreadyout_d = (state_d == ST_IDLE) || (penable_d && (wait_cnt_d == WAIT_MAX));
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            sel_q       <= 3'b000;
            pselx_q     <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            sel_q       <= sel_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Pselx     = pselx_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

    // Read data is forwarded straight from the slave on the completing cycle.
    assign Hrdata = ((state_q == ST_RACCESS) && hreadyout_q) ? Prdata : '0;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: two instances (ACCESS_WAIT 0 and 3) share one
// stimulus stream and are each compared every cycle against a transaction model.
module tb_apb_fsm_controller;

    logic        Hclk;
    logic        Hresetn;
    logic        Valid;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic [2:0]  Tempselx;
    logic [31:0] Prdata;

    logic        pwrite0, penable0, hready0;
    logic [2:0]  pselx0;
    logic [31:0] paddr0, pwdata0, hrdata0;
    logic        pwrite3, penable3, hready3;
    logic [2:0]  pselx3;
    logic [31:0] paddr3, pwdata3, hrdata3;

    int n_chk  = 0;
    int n_fail = 0;

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .ACCESS_WAIT(0)) dut0 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Valid(Valid), .Haddr(Haddr), .Hwrite(Hwrite),
        .Hwdata(Hwdata), .Tempselx(Tempselx), .Prdata(Prdata), .Pwrite(pwrite0),
        .Penable(penable0), .Pselx(pselx0), .Paddr(paddr0), .Pwdata(pwdata0),
        .Hreadyout(hready0), .Hrdata(hrdata0)
    );

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .ACCESS_WAIT(3)) dut3 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Valid(Valid), .Haddr(Haddr), .Hwrite(Hwrite),
        .Hwdata(Hwdata), .Tempselx(Tempselx), .Prdata(Prdata), .Pwrite(pwrite3),
        .Penable(penable3), .Pselx(pselx3), .Paddr(paddr3), .Pwdata(pwdata3),
        .Hreadyout(hready3), .Hrdata(hrdata3)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Transaction model: a transfer is tracked by its age in cycles since accept.
    // Write: age 1 = data wait, age 2 = setup, ages 3..len = access (len = 3+wait).
    // Read:  age 1 = setup, ages 2..len = access (len = 2+wait).
    bit          m_busy [2];
    bit          m_wr   [2];
    int          m_age  [2];
    int          m_len  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [2:0]  m_sel  [2];
    logic        m_dir  [2];

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    always @(posedge Hclk or negedge Hresetn) begin
        for (int i = 0; i < 2; i++) begin
            if (!Hresetn) begin
                m_busy[i] <= 1'b0;
                m_wr[i]   <= 1'b0;
                m_age[i]  <= 0;
                m_len[i]  <= 0;
                m_addr[i] <= '0;
                m_data[i] <= '0;
                m_sel[i]  <= '0;
                m_dir[i]  <= 1'b0;
            end else if (!m_busy[i] || m_age[i] == m_len[i]) begin
                if (Valid) begin
                    m_busy[i] <= 1'b1;
                    m_wr[i]   <= Hwrite;
                    m_age[i]  <= 1;
                    m_len[i]  <= (Hwrite ? 3 : 2) + wait_of(i);
                    m_addr[i] <= Haddr;
                    m_sel[i]  <= Tempselx;
                    m_dir[i]  <= Hwrite;
                end else begin
                    m_busy[i] <= 1'b0;
                end
            end else begin
                if (m_wr[i] && m_age[i] == 1) m_data[i] <= Hwdata;
                m_age[i] <= m_age[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input int i, input logic [2:0] sel_a, input logic pen_a,
                             input logic pw_a, input logic [31:0] pa_a,
                             input logic [31:0] pwd_a, input logic hr_a,
                             input logic [31:0] hrd_a);
        int    su;
        bit    setup, acc, fin;
        string p;
        p     = $sformatf("dut%0d_", wait_of(i));
        su    = m_wr[i] ? 2 : 1;
        setup = m_busy[i] && (m_age[i] == su);
        acc   = m_busy[i] && (m_age[i] > su);
        fin   = m_busy[i] && (m_age[i] == m_len[i]);
        chk({p, "pselx"},   32'(sel_a), (setup || acc) ? 32'(m_sel[i]) : 32'd0);
        chk({p, "penable"}, 32'(pen_a), 32'(acc));
        chk({p, "hready"},  32'(hr_a),  32'(!m_busy[i] || fin));
        chk({p, "hrdata"},  hrd_a,      (fin && !m_wr[i]) ? Prdata : 32'd0);
        chk({p, "pwdata"},  pwd_a,      m_data[i]);
        // Address/direction are only defined once the APB phases start or in IDLE.
        if (!(m_busy[i] && m_wr[i] && m_age[i] == 1)) begin
            chk({p, "paddr"},  pa_a,       m_addr[i]);
            chk({p, "pwrite"}, 32'(pw_a),  32'(m_dir[i]));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [2:0] s, input logic [31:0] pr);
        Valid = v; Haddr = a; Hwrite = w; Hwdata = d; Tempselx = s; Prdata = pr;
    endtask

    task automatic check_models();
        #1;
        cmp_model(0, pselx0, penable0, pwrite0, paddr0, pwdata0, hready0, hrdata0);
        cmp_model(1, pselx3, penable3, pwrite3, paddr3, pwdata3, hready3, hrdata3);
    endtask

    task automatic advance();
        @(posedge Hclk);
        #1;
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [2:0] s, input logic [31:0] pr);
        drive(v, a, w, d, s, pr);
        check_models();
        advance();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 32'd0, 3'b000, 32'hA5A5_5A5A);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [2:0]  s;
        logic [31:0] pr;
        logic [2:0]  e_sel;
        logic        e_pen;
        logic        e_hr;
        logic        chk_lat;
        logic        e_pw;
        logic [31:0] e_pa;
        logic [31:0] e_pwd;
        logic [31:0] e_hrd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Directed write then read on the ACCESS_WAIT=0 instance, one row per cycle.
        tbl[0] = '{1'b1, 32'h8000_0010, 1'b1, 32'h0,         3'b001, 32'h0,
                   3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0};
        tbl[1] = '{1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 3'b000, 32'h0,
                   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0};
        tbl[2] = '{1'b0, 32'h0,         1'b0, 32'h0,         3'b000, 32'h0,
                   3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0};
        tbl[3] = '{1'b0, 32'h0,         1'b0, 32'h0,         3'b000, 32'h0,
                   3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0};
        tbl[4] = '{1'b1, 32'h8000_0020, 1'b0, 32'h0,         3'b010, 32'hCAFE_F00D,
                   3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 32'h0,         3'b000, 32'hCAFE_F00D,
                   3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'hDEAD_BEEF, 32'h0};
        tbl[6] = '{1'b0, 32'h0,         1'b0, 32'h0,         3'b000, 32'hCAFE_F00D,
                   3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 32'h0,         3'b000, 32'hCAFE_F00D,
                   3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'hDEAD_BEEF, 32'h0};

        Hresetn = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 3'b000, 32'h5555_AAAA);
        repeat (2) @(posedge Hclk);
        #1;
        chk("rst_hready0", 32'(hready0), 32'd1);
        chk("rst_pselx0",  32'(pselx0),  32'd0);
        chk("rst_penable0", 32'(penable0), 32'd0);
        chk("rst_pwrite0", 32'(pwrite0), 32'd0);
        chk("rst_paddr0",  paddr0,       32'd0);
        chk("rst_pwdata0", pwdata0,      32'd0);
        chk("rst_hrdata0", hrdata0,      32'd0);
        chk("rst_hready3", 32'(hready3), 32'd1);
        chk("rst_pselx3",  32'(pselx3),  32'd0);
        Hresetn = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].a, tbl[k].w, tbl[k].d, tbl[k].s, tbl[k].pr);
            check_models();
            chk($sformatf("tbl%0d_pselx", k),   32'(pselx0),   32'(tbl[k].e_sel));
            chk($sformatf("tbl%0d_penable", k), 32'(penable0), 32'(tbl[k].e_pen));
            chk($sformatf("tbl%0d_hready", k),  32'(hready0),  32'(tbl[k].e_hr));
            chk($sformatf("tbl%0d_pwdata", k),  pwdata0,       tbl[k].e_pwd);
            chk($sformatf("tbl%0d_hrdata", k),  hrdata0,       tbl[k].e_hrd);
            if (tbl[k].chk_lat) begin
                chk($sformatf("tbl%0d_pwrite", k), 32'(pwrite0), 32'(tbl[k].e_pw));
                chk($sformatf("tbl%0d_paddr", k),  paddr0,       tbl[k].e_pa);
            end
            advance();
        end
        idle(8);

        // Write followed by a read held on Valid: read setup follows write access directly.
        step(1'b1, 32'h4000_0100, 1'b1, 32'h0, 3'b100, 32'h0BAD_F00D);
        drive(1'b1, 32'h4000_0200, 1'b0, 32'h1234_5678, 3'b010, 32'h0BAD_F00D);
        check_models();
        advance();
        drive(1'b1, 32'h4000_0200, 1'b0, 32'h0, 3'b010, 32'h0BAD_F00D);
        check_models();
        chk("b2b_wsetup_pwdata", pwdata0, 32'h1234_5678);
        advance();
        check_models();
        chk("b2b_waccess_hready", 32'(hready0), 32'd1);
        chk("b2b_waccess_pselx",  32'(pselx0),  32'b100);
        advance();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0BAD_F00D);
        check_models();
        chk("b2b_rsetup_pselx",   32'(pselx0),   32'b010);
        chk("b2b_rsetup_penable", 32'(penable0), 32'd0);
        chk("b2b_rsetup_pwrite",  32'(pwrite0),  32'd0);
        chk("b2b_rsetup_paddr",   paddr0,        32'h4000_0200);
        advance();
        check_models();
        chk("b2b_raccess_hrdata", hrdata0, 32'h0BAD_F00D);
        advance();
        idle(10);

        // Read on the ACCESS_WAIT=3 instance: four ACCESS cycles, ready only on the last.
        step(1'b1, 32'h8000_0020, 1'b0, 32'h0, 3'b001, 32'h7777_1111);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h7777_1111);
        check_models();
        chk("w3_setup_penable", 32'(penable3), 32'd0);
        chk("w3_setup_pselx",   32'(pselx3),   32'b001);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h7777_1111);
            check_models();
            chk($sformatf("w3_acc%0d_penable", k), 32'(penable3), 32'd1);
            chk($sformatf("w3_acc%0d_hready", k),  32'(hready3),  32'(k == 3));
            chk($sformatf("w3_acc%0d_paddr", k),   paddr3,        32'h8000_0020);
            chk($sformatf("w3_acc%0d_hrdata", k),  hrdata3, (k == 3) ? 32'h7777_1111 : 32'h0);
            advance();
        end
        check_models();
        chk("w3_done_penable", 32'(penable3), 32'd0);
        advance();
        idle(4);

        // Asynchronous reset in the middle of a write access.
        step(1'b1, 32'h9000_0040, 1'b1, 32'h0, 3'b001, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h1111_2222, 3'b000, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0);
        check_models();
        chk("pre_rst_penable", 32'(penable0), 32'd1);
        #1;
        Hresetn = 1'b0;
        #1;
        chk("arst_penable", 32'(penable0), 32'd0);
        chk("arst_pselx",   32'(pselx0),   32'd0);
        chk("arst_pwrite",  32'(pwrite0),  32'd0);
        chk("arst_paddr",   paddr0,        32'd0);
        chk("arst_pwdata",  pwdata0,       32'd0);
        chk("arst_hready",  32'(hready0),  32'd1);
        advance();
        Hresetn = 1'b1;
        step(1'b1, 32'h9000_0080, 1'b1, 32'h0, 3'b010, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h3333_4444, 3'b000, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0);
        check_models();
        chk("post_rst_pselx",  32'(pselx0), 32'b010);
        chk("post_rst_pwdata", pwdata0,     32'h3333_4444);
        advance();
        idle(8);

        // Valid pulsed while busy must not start a second transfer.
        step(1'b1, 32'h2000_0004, 1'b1, 32'h0, 3'b001, 32'h0);
        step(1'b1, 32'h2000_0008, 1'b0, 32'h0000_0011, 3'b010, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0);
            check_models();
            chk($sformatf("ign%0d_pselx", k),   32'(pselx0),   32'd0);
            chk($sformatf("ign%0d_penable", k), 32'(penable0), 32'd0);
            chk($sformatf("ign%0d_paddr", k),   paddr0,        32'h2000_0004);
            advance();
        end
        idle(8);

        // Random traffic, including zero and multi-hot selects.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom, 3'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
